// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: forwarding selects, load-use stalls,
// data-memory wait stalls and control-flow flush. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_wen,
  input  logic             mem_is_load,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_wen,
  input  logic             ex_uses_rs2,
  input  logic             ctl_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes,
`endif
  output logic [1:0]       hz_state
);

  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} hzState_t;

  localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

  hzState_t   state, nextState;
  logic [1:0] bubbleCnt, nextCnt;
  logic       memHitA, wbHitA, memHitB, wbHitB;
  logic       loadUse, memWait;
  logic       stallFront, stallBack, bubbleExC, bubbleWbC, flushC;
  logic       unusedInputs;

  // Load data is only ever forwarded from WB or MEM once it exists, so the MEM load flag is not needed.
  assign unusedInputs = mem_is_load;

  assign memHitA = mem_wen && (mem_rd != '0) && (mem_rd == ex_rs1);
  assign wbHitA  = wb_wen  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
  assign memHitB = mem_wen && (mem_rd != '0) && (mem_rd == ex_rs2);
  assign wbHitB  = wb_wen  && (wb_rd  != '0) && (wb_rd  == ex_rs2);

  assign fwd_a    = memHitA ? 2'b10 : (wbHitA ? 2'b01 : 2'b00);
  assign fwd_b    = !ex_uses_rs2 ? 2'b00 : (memHitB ? 2'b10 : (wbHitB ? 2'b01 : 2'b00));
  assign fwd_id_a = wb_wen && (wb_rd != '0) && (wb_rd == id_rs1);
  assign fwd_id_b = wb_wen && (wb_rd != '0) && (wb_rd == id_rs2);

  assign loadUse = ex_is_load && ex_wen && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // dmem_req/dmem_ready: an access is outstanding while dmem_req is high and completes in the
  // cycle dmem_ready is high; every earlier dmem_req cycle without dmem_ready is a wait state.
  assign memWait = dmem_req && !dmem_ready;

  always_comb begin
    nextState  = state;
    nextCnt    = bubbleCnt;
    stallFront = 1'b0;
    stallBack  = 1'b0;
    bubbleExC  = 1'b0;
    bubbleWbC  = 1'b0;
    flushC     = 1'b0;
    case (state)
      RUN, LU_STALL: begin
        if (memWait) begin
          stallFront = 1'b1;
          stallBack  = 1'b1;
          bubbleWbC  = 1'b1;
          nextCnt    = 2'd0;
          nextState  = MEM_WAIT;
        end else if (ctl_taken) begin
          flushC    = 1'b1;
          nextCnt   = 2'd0;
          nextState = RUN;
        end else if (state == LU_STALL) begin
          stallFront = 1'b1;
          bubbleExC  = 1'b1;
          nextCnt    = bubbleCnt - 2'd1;
          nextState  = (bubbleCnt == 2'd1) ? RUN : LU_STALL;
        end else if (loadUse) begin
          stallFront = 1'b1;
          bubbleExC  = 1'b1;
          nextCnt    = LU_RELOAD;
          nextState  = (LU_RELOAD != 2'd0) ? LU_STALL : RUN;
        end
      end
      // The frozen MEM instruction cannot be a branch, so ctl_taken is not looked at here.
      MEM_WAIT: begin
        if (!dmem_ready) begin
          stallFront = 1'b1;
          stallBack  = 1'b1;
          bubbleWbC  = 1'b1;
        end else begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = RUN;
        nextCnt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      bubbleCnt <= 2'd0;
    end else begin
      state     <= nextState;
      bubbleCnt <= nextCnt;
    end
  end

  // Controls are forced low while reset is held so the pipeline sees no stray stall or flush.
  assign stall_if     = stallFront && !reset;
  assign stall_id     = stallFront && !reset;
  assign stall_ex     = stallBack  && !reset;
  assign stall_mem    = stallBack  && !reset;
  assign bubble_ex    = bubbleExC  && !reset;
  assign bubble_wb    = bubbleWbC  && !reset;
  assign flush_if_id  = flushC     && !reset;
  assign flush_id_ex  = flushC     && !reset;
  assign flush_ex_mem = flushC     && !reset;
  assign hz_state     = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (stall_if && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if (flush_if_id && (perf_flushes != '1))
        perf_flushes <= perf_flushes + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (LU_BUBBLES=2): forwarding, load-use, memory wait,
// event priority, asynchronous reset and, when HAZARD_PERF_CNT_EN is defined, perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int RA_W = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic            ex_wen, ex_is_load, mem_wen, mem_is_load, wb_wen, ex_uses_rs2;
  logic            ctl_taken, dmem_req, dmem_ready;
  logic [1:0]      fwd_a, fwd_b, hz_state;
  logic            fwd_id_a, fwd_id_b, stall_if, stall_id, stall_ex, stall_mem;
  logic            bubble_ex, bubble_wb, flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles, perf_flushes;
  logic [1:0]      sat_stall_cycles, sat_flushes;
  logic [1:0]      s_fwd_a, s_fwd_b, s_hz_state;
  logic            s_fwd_id_a, s_fwd_id_b, s_stall_if, s_stall_id, s_stall_ex, s_stall_mem;
  logic            s_bubble_ex, s_bubble_wb, s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  logic [7:0]  obs8;
  logic [2:0]  flush3;
  logic [5:0]  fwd_v;
  assign obs8   = {hz_state, stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb};
  assign flush3 = {flush_if_id, flush_id_ex, flush_ex_mem};
  assign fwd_v  = {fwd_a, fwd_b, fwd_id_a, fwd_id_b};

  pipeline_hazard_ctrl #(.RA_W(RA_W), .LU_BUBBLES(2), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .ex_uses_rs2(ex_uses_rs2), .ctl_taken(ctl_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .bubble_wb(bubble_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
`endif
    .hz_state(hz_state)
  );

`ifdef HAZARD_PERF_CNT_EN
  pipeline_hazard_ctrl #(.RA_W(RA_W), .LU_BUBBLES(2), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .ex_uses_rs2(ex_uses_rs2), .ctl_taken(ctl_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_id_a(s_fwd_id_a), .fwd_id_b(s_fwd_id_b),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex), .stall_mem(s_stall_mem),
    .bubble_ex(s_bubble_ex), .bubble_wb(s_bubble_wb), .flush_if_id(s_flush_if_id),
    .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
    .perf_stall_cycles(sat_stall_cycles), .perf_flushes(sat_flushes),
    .hz_state(s_hz_state)
  );
`endif

  // Clock
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic quiet();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_wen = 1'b0; ex_is_load = 1'b0; mem_wen = 1'b0; mem_is_load = 1'b0; wb_wen = 1'b0;
    ex_uses_rs2 = 1'b0; ctl_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic drive_fwd(input logic mw, input logic [4:0] mrd, input logic ww,
                           input logic [4:0] wrd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] i1, input logic [4:0] i2);
    mem_wen = mw; mem_rd = mrd; wb_wen = ww; wb_rd = wrd;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_uses_rs2 = u2; id_rs1 = i1; id_rs2 = i2;
  endtask

  // Row bits: {ctl_taken, dmem_req, dmem_ready, load-use on x7}
  task automatic drive_row(input logic [3:0] r);
    ctl_taken  = r[3];
    dmem_req   = r[2];
    dmem_ready = r[1];
    ex_is_load = r[0];
    ex_wen     = r[0];
    ex_rd      = r[0] ? 5'd7 : 5'd0;
    id_rs1     = r[0] ? 5'd7 : 5'd0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    quiet();
    step(); step(); #1;
    n_vec++; if (hz_state !== 2'd0) begin n_err++; $display("FAIL reset_state: hz_state=%0d expected 0", hz_state); end
    n_vec++; if (obs8 !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: %b expected 00000000", obs8); end
    n_vec++; if (flush3 !== 3'b000) begin n_err++; $display("FAIL reset_flush: %b expected 000", flush3); end
    n_vec++; if (fwd_v !== 6'b000000) begin n_err++; $display("FAIL reset_fwd: %b expected 000000", fwd_v); end
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [5:0] exp_fwd [10] = '{6'b100000, 6'b000000, 6'b010000, 6'b000000, 6'b001000,
                                 6'b000000, 6'b100100, 6'b000010, 6'b000001, 6'b000000};
    quiet();
    for (int i = 0; i < 10; i++) begin
      step();
      case (i)
        0: drive_fwd(1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        1: drive_fwd(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0);
        2: drive_fwd(1'b1, 5'd6, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        3: drive_fwd(1'b0, 5'd5, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 5'd5);
        4: drive_fwd(1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 5'd0);
        5: drive_fwd(1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 5'd0, 5'd0);
        6: drive_fwd(1'b1, 5'd3, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 5'd0, 5'd0);
        7: drive_fwd(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd3, 5'd4);
        8: drive_fwd(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 5'd3);
        default: drive_fwd(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
      endcase
      #1;
      n_vec++;
      if (fwd_v !== exp_fwd[i]) begin
        n_err++; $display("FAIL fwd_vec%0d: {fwd_a,fwd_b,id_a,id_b}=%b expected %b", i, fwd_v, exp_fwd[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] stim [3] = '{4'b0001, 4'b0000, 4'b0000};
    logic [10:0] exp_w, got_w;
    quiet();
    exp_q.push_back({3'b000, 8'b00_1100_10});
    exp_q.push_back({3'b000, 8'b01_1100_10});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    for (int i = 0; i < 3; i++) begin
      step(); drive_row(stim[i]); #1;
      exp_w = exp_q.pop_front(); got_w = {flush3, obs8};
      n_vec++;
      if (got_w !== exp_w) begin n_err++; $display("FAIL load_use_c%0d: got %b expected %b", i, got_w, exp_w); end
    end
    step();
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL load_use_x0: stall_if=%b expected 0", stall_if); end
    quiet();
  endtask

  task automatic test_mem_wait();
    logic [3:0] stim [5] = '{4'b0100, 4'b1100, 4'b0100, 4'b0110, 4'b0000};
    logic [10:0] exp_w, got_w;
    quiet();
    exp_q.push_back({3'b000, 8'b00_1111_01});
    exp_q.push_back({3'b000, 8'b10_1111_01});
    exp_q.push_back({3'b000, 8'b10_1111_01});
    exp_q.push_back({3'b000, 8'b10_0000_00});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    for (int i = 0; i < 5; i++) begin
      step(); drive_row(stim[i]); #1;
      exp_w = exp_q.pop_front(); got_w = {flush3, obs8};
      n_vec++;
      if (got_w !== exp_w) begin n_err++; $display("FAIL mem_wait_c%0d: got %b expected %b", i, got_w, exp_w); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] stim [5] = '{4'b1001, 4'b0000, 4'b1100, 4'b0110, 4'b0000};
    logic [10:0] exp_w, got_w;
    quiet();
    exp_q.push_back({3'b111, 8'b00_0000_00});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    exp_q.push_back({3'b000, 8'b00_1111_01});
    exp_q.push_back({3'b000, 8'b10_0000_00});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    for (int i = 0; i < 5; i++) begin
      step(); drive_row(stim[i]); #1;
      exp_w = exp_q.pop_front(); got_w = {flush3, obs8};
      n_vec++;
      if (got_w !== exp_w) begin n_err++; $display("FAIL simultaneous_c%0d: got %b expected %b", i, got_w, exp_w); end
    end
  endtask

  task automatic test_lu_abort();
    logic [3:0] stim [8] = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 4'b0110, 4'b0000};
    logic [10:0] exp_w, got_w;
    quiet();
    exp_q.push_back({3'b000, 8'b00_1100_10});
    exp_q.push_back({3'b111, 8'b01_0000_00});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    exp_q.push_back({3'b000, 8'b00_1100_10});
    exp_q.push_back({3'b000, 8'b01_1111_01});
    exp_q.push_back({3'b000, 8'b10_1111_01});
    exp_q.push_back({3'b000, 8'b10_0000_00});
    exp_q.push_back({3'b000, 8'b00_0000_00});
    for (int i = 0; i < 8; i++) begin
      step(); drive_row(stim[i]); #1;
      exp_w = exp_q.pop_front(); got_w = {flush3, obs8};
      n_vec++;
      if (got_w !== exp_w) begin n_err++; $display("FAIL lu_abort_c%0d: got %b expected %b", i, got_w, exp_w); end
    end
  endtask

  task automatic test_reset_mid();
    quiet();
    step(); drive_row(4'b0100);
    step(); drive_row(4'b0100); #1;
    n_vec++; if (hz_state !== 2'd2) begin n_err++; $display("FAIL rst_mid_pre: hz_state=%0d expected 2", hz_state); end
    #2 reset = 1'b1;
    quiet();
    #1;
    n_vec++; if (hz_state !== 2'd0) begin n_err++; $display("FAIL rst_mid_async: hz_state=%0d expected 0", hz_state); end
    n_vec++; if ({flush3, obs8} !== 11'd0) begin n_err++; $display("FAIL rst_mid_ctrl: %b expected 0", {flush3, obs8}); end
    step(); #1;
    n_vec++; if ({flush3, obs8} !== 11'd0) begin n_err++; $display("FAIL rst_mid_hold: %b expected 0", {flush3, obs8}); end
    reset = 1'b0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    logic [3:0] stim [11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0110, 4'b0000,
                              4'b1000, 4'b0000, 4'b1000, 4'b0000};
    quiet();
    step(); reset = 1'b1;
    step(); reset = 1'b0; #1;
    n_vec++; if (perf_stall_cycles !== 32'd0) begin n_err++; $display("FAIL perf_rst_stall: %0d expected 0", perf_stall_cycles); end
    n_vec++; if (perf_flushes !== 32'd0) begin n_err++; $display("FAIL perf_rst_flush: %0d expected 0", perf_flushes); end
    for (int i = 0; i < 11; i++) begin
      step(); drive_row(stim[i]);
    end
    step(); #1;
    n_vec++; if (perf_stall_cycles !== 32'd4) begin n_err++; $display("FAIL perf_stall: %0d expected 4", perf_stall_cycles); end
    n_vec++; if (perf_flushes !== 32'd2) begin n_err++; $display("FAIL perf_flush: %0d expected 2", perf_flushes); end
    n_vec++; if (sat_stall_cycles !== 2'd3) begin n_err++; $display("FAIL perf_sat_stall: %0d expected 3", sat_stall_cycles); end
    n_vec++; if (sat_flushes !== 2'd2) begin n_err++; $display("FAIL perf_sat_flush: %0d expected 2", sat_flushes); end
  endtask
`endif

  initial begin
    quiet();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_simultaneous();
    test_lu_abort();
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Centralised hazard controller for the five-stage RV32 core (IF, ID, EX, MEM, WB). It generalises the core's current forwarding scheme and adds several controls the pipeline does not yet have: load-use stall detection, data-memory wait-state handling, and sequenced control flush. It produces every stall, flush, bubble and forwarding-select signal for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Branch and jump resolution stays in MEM; this block only reacts to it.

## Interface
Parameters:
- RA_W, 5: register-address width.
- LU_BUBBLES, 1: bubbles inserted per load-use hazard (1..3). Use 1 when MEM-stage load forwarding exists.
- CNT_W, 32: performance-counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID.
- ex_rs1, ex_rs2, ex_rd  in  RA_W  EX-stage source and destination registers.
- ex_wen, ex_is_load  in  1  EX writes rd / EX is a load.
- mem_rd  in  RA_W; mem_wen, mem_is_load  in  1  MEM-stage equivalents.
- wb_rd  in  RA_W; wb_wen  in  1  WB-stage equivalents.
- ex_uses_rs2  in  1  EX operand B comes from rs2 (not immediate).
- ctl_taken  in  1  taken branch, jal or jalr resolved in MEM.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB value, 10 MEM value.
- fwd_id_a, fwd_id_b  out  1  WB-to-ID bypass.
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the pipeline register feeding that stage.
- bubble_ex  out  1  load a NOP into ID/EX.
- bubble_wb  out  1  load a NOP into MEM/WB.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear the register.
- hz_state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.

## Operation
- Register x0 never matches any hazard or forwarding comparison.
- Forwarding (combinational):
  - fwd_a = 10 if mem_wen && mem_rd==ex_rs1.
  - Otherwise fwd_a = 01 if wb_wen && wb_rd==ex_rs1.
  - Otherwise fwd_a = 00.
  - fwd_b uses the same rules with ex_rs2, gated by ex_uses_rs2.
  - fwd_id_x = wb_wen && wb_rd==id_rsx.
- Load-use hazard: ex_is_load && ex_wen && ex_rd∈{id_rs1,id_rs2}.
- Priority of events each cycle: MEM_WAIT > ctl_taken > load-use.
- RUN state:
  - If dmem_req && !dmem_ready: stall_if/id/ex/mem=1, bubble_wb=1, next state MEM_WAIT.
  - Else if ctl_taken: flush_if_id, flush_id_ex and flush_ex_mem=1 for this cycle. Any simultaneous load-use is discarded. Stay in RUN.
  - Else if load-use: stall_if=stall_id=1, bubble_ex=1. The bubble counter is loaded with LU_BUBBLES-1. Next state is LU_STALL if the counter is nonzero, else RUN.
- LU_STALL state:
  - Asserts stall_if, stall_id and bubble_ex, and decrements the counter.
  - Returns to RUN when the counter reaches 0.
  - ctl_taken here flushes as in RUN, aborts the stall and returns to RUN.
  - A memory wait here moves to MEM_WAIT; the remaining bubbles are discarded.
- MEM_WAIT state:
  - Holds all stall_* and bubble_wb while !dmem_ready.
  - In the dmem_ready cycle all stalls drop and the next state is RUN.
  - ctl_taken is ignored until the wait ends, because the MEM instruction is frozen.

## Timing
- Forwarding, stall, flush and bubble outputs are combinational from the registered state and the current inputs. They are valid the same cycle and sampled by pipeline registers at the next rising edge.
- State and counter registers update on the rising edge of clock.
- Reset (asynchronous, any time including mid-stall):
  - hz_state=0 (RUN), bubble counter=0, performance counters=0.
  - With inputs quiescent, all outputs are 0.
- Load-use penalty is exactly LU_BUBBLES cycles. Branch penalty is exactly 3 flushed slots, with no extra cycles.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cycles and perf_flushes, both CNT_W bits.
  - perf_stall_cycles increments in every cycle with stall_if=1.
  - perf_flushes increments in every cycle with flush_if_id=1.
  - Both counters saturate at all-ones and are cleared by reset.
- HAZARD_PERF_CNT_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- Forwarding: mem_wen=1, mem_rd=5, wb_wen=1, wb_rd=5, ex_rs1=5 -> fwd_a=10. With mem_rd=0 and wb_rd=0 -> fwd_a=00.
- Load-use, LU_BUBBLES=2: ex_is_load, ex_rd=7, id_rs2=7 -> stall_if=1 and bubble_ex=1 for exactly 2 cycles, then 0; hz_state goes 0,1,0.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> all stalls and bubble_wb=1 for 3 cycles, released in the ready cycle; hz_state=2 during the wait.
- Simultaneous events: ctl_taken=1 plus load-use in the same cycle -> all three flushes=1, bubble_ex=0, state stays RUN.
- Reset mid-operation: assert reset during MEM_WAIT -> hz_state=0 and all outputs 0 immediately, without waiting for a clock edge.
- With HAZARD_PERF_CNT_EN: 4 stall cycles and 2 flushes -> perf_stall_cycles=4, perf_flushes=2. With CNT_W=2 the counter saturates at 3.
